sterownik_pwm: RTL and testbench

Speed-stage PWM generator sitting directly downstream of the button-driven speed selector. It latches the selector's speed setpoint (0–100 %, 5 % steps) on the selector's change strobe and ramps the applied duty toward it one percent at a time. It drives the motor power switch with a fixed-period PWM and returns the latched setpoint to the selector's current-speed input, closing the adjust loop.

---
 rtl/sterownik_pwm_pkg.sv | 29 ++
 rtl/sterownik_pwm_licznik.sv | 55 +++++
 rtl/sterownik_pwm.sv | 145 ++++++++++++++
 tb/tb_sterownik_pwm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sterownik_pwm_pkg.sv
// -----------------------------------------------------------------------------
// sterownik_pwm_pkg
// Shared motor-stage constants, the controller state encoding and the
// setpoint saturation helper used by sterownik_pwm and licznik_pwm.
// -----------------------------------------------------------------------------
package sterownik_pwm_pkg;

  localparam int MAX_RPM   = 100;  // highest legal setpoint / duty, percent
  localparam int PWM_STEPS = 100;  // ticks per PWM period
  localparam int RPM_W     = 7;    // width of every percent-valued signal

  // Controller states: stopped, steady, ramping up, ramping down.
  typedef enum logic [1:0] {
    STOJ   = 2'd0,
    STALA  = 2'd1,
    W_GORE = 2'd2,
    W_DOL  = 2'd3
  } stan_t;

  // Clamp a raw 7-bit selector value into 0..MAX_RPM.
  function automatic logic [RPM_W-1:0] nasyc_rpm(input logic [RPM_W-1:0] v);
    if (v > RPM_W'(MAX_RPM)) begin
      return RPM_W'(MAX_RPM);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sterownik_pwm_licznik.sv
// -----------------------------------------------------------------------------
// licznik_pwm
// Prescaler plus PWM period counter. The prescaler counts 0..PRESCALER-1 and
// emits a tick on its terminal count; each tick advances the period counter
// 0..PWM_STEPS-1, wrapping. period_end marks the tick that closes a period.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   tick       out  one clk pulse per PWM tick
//   period_end out  tick coinciding with period counter = PWM_STEPS-1
//   period_cnt out  current position inside the PWM period (0..99)
// -----------------------------------------------------------------------------
module licznik_pwm
  import sterownik_pwm_pkg::*;
#(
  parameter int PRESCALER = 100
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic             period_end,
  output logic [RPM_W-1:0] period_cnt
);

  localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;

  logic [PW-1:0]    presc_r;
  logic [RPM_W-1:0] cnt_r;
  logic             tick_s;
  logic             last_step_s;

  assign tick_s      = (presc_r == PW'(PRESCALER - 1));
  assign last_step_s = (cnt_r == RPM_W'(PWM_STEPS - 1));

  assign tick        = tick_s;
  assign period_end  = tick_s & last_step_s;
  assign period_cnt  = cnt_r;

  // Prescaler and period counter; both run freely regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      cnt_r   <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
      if (last_step_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + RPM_W'(1);
      end
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

endmodule

// File: rtl/sterownik_pwm.sv
// -----------------------------------------------------------------------------
// sterownik_pwm
// Speed-stage PWM generator. Latches the selector's setpoint on its change
// strobe (saturated to 100 %), ramps the applied duty toward it by 1 % every
// RAMP_PERIODS PWM periods, and drives a registered fixed-period PWM.
//   clk               in   system clock
//   rst               in   asynchronous active-high reset
//   rpm               in   setpoint from selector, percent
//   sygnal_zmiany_rpm in   one-cycle strobe: latch rpm
//   enable            in   motor enable level
//   zadane_rpm        out  latched setpoint (reset INIT_RPM)
//   aktualne_rpm      out  applied duty, percent (reset 0)
//   pwm_out           out  registered PWM drive (reset 0)
//   w_rampie          out  high while enabled and duty differs from setpoint
// -----------------------------------------------------------------------------
module sterownik_pwm
  import sterownik_pwm_pkg::*;
#(
  parameter int PRESCALER    = 100,
  parameter int RAMP_PERIODS = 4,
  parameter int INIT_RPM     = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RPM_W-1:0] rpm,
  input  logic             sygnal_zmiany_rpm,
  input  logic             enable,
  output logic [RPM_W-1:0] zadane_rpm,
  output logic [RPM_W-1:0] aktualne_rpm,
  output logic             pwm_out,
  output logic             w_rampie
);

  localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  logic             tick_s;
  logic             period_end_s;
  logic [RPM_W-1:0] period_cnt_s;
  logic             krok_s;

  stan_t            stan_r;
  stan_t            stan_nxt_s;
  logic [RPM_W-1:0] zadane_r;
  logic [RPM_W-1:0] zadane_nxt_s;
  logic [RPM_W-1:0] aktualne_r;
  logic [RPM_W-1:0] aktualne_nxt_s;
  logic [RC_W-1:0]  ramp_r;
  logic [RC_W-1:0]  ramp_nxt_s;
  logic             pwm_r;
  logic             w_rampie_r;

  licznik_pwm #(
    .PRESCALER (PRESCALER)
  ) u_licznik (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_s),
    .period_end (period_end_s),
    .period_cnt (period_cnt_s)
  );

  // A period end is by construction also a tick.
  assign krok_s = tick_s & period_end_s;

  // Next-state: setpoint latch, ramp step and state selection.
  always_comb begin
    zadane_nxt_s   = zadane_r;
    aktualne_nxt_s = aktualne_r;
    ramp_nxt_s     = ramp_r;
    stan_nxt_s     = stan_r;

    if (sygnal_zmiany_rpm) begin
      zadane_nxt_s = nasyc_rpm(rpm);
    end else begin
      zadane_nxt_s = zadane_r;
    end

    if (!enable) begin
      stan_nxt_s     = STOJ;
      aktualne_nxt_s = '0;
      ramp_nxt_s     = '0;
    end else begin
      // The step direction comes from the registered state, so a strobe in
      // the same cycle only steers the following step.
      case (stan_r)
        W_GORE, W_DOL: begin
          if (krok_s) begin
            if (ramp_r == RC_W'(RAMP_PERIODS - 1)) begin
              ramp_nxt_s = '0;
              if (stan_r == W_GORE) begin
                aktualne_nxt_s = aktualne_r + RPM_W'(1);
              end else begin
                aktualne_nxt_s = aktualne_r - RPM_W'(1);
              end
            end else begin
              ramp_nxt_s = ramp_r + RC_W'(1);
            end
          end else begin
            ramp_nxt_s = ramp_r;
          end
        end
        default: begin
          aktualne_nxt_s = aktualne_r;
          ramp_nxt_s     = ramp_r;
        end
      endcase

      // Leaving STOJ and every setpoint change land here: the state always
      // mirrors the relation between the next duty and the next setpoint.
      if (aktualne_nxt_s < zadane_nxt_s) begin
        stan_nxt_s = W_GORE;
      end else if (aktualne_nxt_s > zadane_nxt_s) begin
        stan_nxt_s = W_DOL;
      end else begin
        stan_nxt_s = STALA;
        ramp_nxt_s = '0;
      end
    end
  end

  // State, setpoint, duty, ramp counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stan_r     <= STOJ;
      zadane_r   <= RPM_W'(INIT_RPM);
      aktualne_r <= '0;
      ramp_r     <= '0;
      pwm_r      <= 1'b0;
      w_rampie_r <= 1'b0;
    end else begin
      stan_r     <= stan_nxt_s;
      zadane_r   <= zadane_nxt_s;
      aktualne_r <= aktualne_nxt_s;
      ramp_r     <= ramp_nxt_s;
      pwm_r      <= enable & (period_cnt_s < aktualne_r);
      w_rampie_r <= (stan_nxt_s == W_GORE) | (stan_nxt_s == W_DOL);
    end
  end

  assign zadane_rpm   = zadane_r;
  assign aktualne_rpm = aktualne_r;
  assign pwm_out      = pwm_r;
  assign w_rampie     = w_rampie_r;

endmodule

// File: tb/tb_sterownik_pwm.sv
// -----------------------------------------------------------------------------
// tb_sterownik_pwm
// Two instances (RAMP_PERIODS=1 and 3, PRESCALER=2) share stimulus. A
// reference model derived from the duty/ramp rules follows each instance
// cycle by cycle; a latch table plus hand-written sequences cover the
// multi-cycle corner cases, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sterownik_pwm;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rpm = 7'd0;
  logic       stb = 1'b0;
  logic       en  = 1'b0;

  logic [6:0] z1, a1, z3, a3;
  logic       p1, w1, p3, w3;

  int errors = 0;
  int checks = 0;

  sterownik_pwm #(.PRESCALER(P), .RAMP_PERIODS(1), .INIT_RPM(50)) dut (
    .clk(clk), .rst(rst), .rpm(rpm), .sygnal_zmiany_rpm(stb), .enable(en),
    .zadane_rpm(z1), .aktualne_rpm(a1), .pwm_out(p1), .w_rampie(w1));

  sterownik_pwm #(.PRESCALER(P), .RAMP_PERIODS(3), .INIT_RPM(50)) dut3 (
    .clk(clk), .rst(rst), .rpm(rpm), .sygnal_zmiany_rpm(stb), .enable(en),
    .zadane_rpm(z3), .aktualne_rpm(a3), .pwm_out(p3), .w_rampie(w3));

  always #5 clk = ~clk;

  typedef struct {
    int zad; int akt; int rc; int pwm; int wr; int enp; int c;
  } model_t;

  typedef struct {
    logic [6:0] rpm;
    int         exp_zad;
  } vec_t;

  model_t m1, m3;

  function automatic model_t mreset();
    model_t m;
    m.zad = 50; m.akt = 0; m.rc = 0; m.pwm = 0; m.wr = 0; m.enp = 0; m.c = 0;
    return m;
  endfunction

  // One clock of the rules: c counts edges since reset, giving the
  // prescaler phase and position in the 100-tick period arithmetically.
  function automatic model_t mstep(model_t m, int rp, int e, int s, int r);
    model_t n = m;
    int ph = m.c % P;
    int k  = (m.c / P) % 100;
    bit pe = (ph == P - 1) && (k == 99);
    n.c   = m.c + 1;
    n.pwm = (e != 0 && k < m.akt) ? 1 : 0;
    n.zad = (s != 0) ? ((r > 100) ? 100 : r) : m.zad;
    if (e == 0) begin
      n.akt = 0; n.rc = 0; n.wr = 0;
    end else begin
      if (m.enp != 0 && m.akt != m.zad && pe) begin
        if (m.rc == rp - 1) begin
          n.akt = m.akt + ((m.zad > m.akt) ? 1 : -1);
          n.rc  = 0;
        end else begin
          n.rc = m.rc + 1;
        end
      end
      if (n.akt == n.zad) n.rc = 0;
      n.wr = (n.akt != n.zad) ? 1 : 0;
    end
    n.enp = e;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_models();
    checks++;
    if (z1 != m1.zad || a1 != m1.akt || p1 != m1.pwm || w1 != m1.wr) begin
      errors++;
      $display("FAIL model_r1 t=%0t: got zad=%0d akt=%0d pwm=%0d wr=%0d expected zad=%0d akt=%0d pwm=%0d wr=%0d",
               $time, z1, a1, p1, w1, m1.zad, m1.akt, m1.pwm, m1.wr);
    end
    checks++;
    if (z3 != m3.zad || a3 != m3.akt || p3 != m3.pwm || w3 != m3.wr) begin
      errors++;
      $display("FAIL model_r3 t=%0t: got zad=%0d akt=%0d pwm=%0d wr=%0d expected zad=%0d akt=%0d pwm=%0d wr=%0d",
               $time, z3, a3, p3, w3, m3.zad, m3.akt, m3.pwm, m3.wr);
    end
  endtask

  // Advance one clock: models see the inputs held across the edge, outputs
  // are compared on the falling edge.
  task automatic cyc();
    model_t n1, n3;
    n1 = mstep(m1, 1, int'(en), int'(stb), int'(rpm));
    n3 = mstep(m3, 3, int'(en), int'(stb), int'(rpm));
    @(posedge clk);
    m1 = n1;
    m3 = n3;
    @(negedge clk);
    chk_models();
  endtask

  task automatic strobe(input int v);
    rpm = 7'(v);
    stb = 1'b1;
    cyc();
    stb = 1'b0;
  endtask

  task automatic wait_a1(input string name, input int target, input int bound);
    int n = 0;
    while (int'(a1) != target && n < bound) begin
      cyc();
      n++;
    end
    chk(name, int'(a1), target);
  endtask

  initial begin
    vec_t tbl[7];
    int   hi, n, prev, mx;

    tbl = '{'{7'd55, 55}, '{7'd0, 0}, '{7'd100, 100}, '{7'd101, 100},
            '{7'd127, 100}, '{7'd5, 5}, '{7'd120, 100}};

    m1 = mreset();
    m3 = mreset();

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_zad", int'(z1), 50);
    chk("reset_akt", int'(a1), 0);
    chk("reset_pwm", int'(p1), 0);
    chk("reset_wr",  int'(w1), 0);

    // Soft start to 50: one step per 200 clk, first at edge 200.
    en = 1'b1;
    #2 rst = 1'b0;
    cyc();
    chk("start_wr", int'(w1), 1);
    repeat (9999) cyc();
    chk("soft_akt", int'(a1), 50);
    chk("soft_wr", int'(w1), 0);
    chk("soft_akt_r3", int'(a3), 16);
    hi = 0;
    repeat (200) begin cyc(); hi += int'(p1); end
    chk("duty50_high_cycles", hi, 100);

    // Slow ramp 50 -> 55 with RAMP_PERIODS=3, strobe aligned after a period end.
    n = 0;
    while ((int'(a3) != 50 || w3) && n < 25000) begin cyc(); n++; end
    chk("r3_settled50", int'(a3), 50);
    while ((m3.c % 200) != 0) cyc();
    prev = int'(a3);
    strobe(55);
    n = 1;
    while (int'(a3) != 55 && n < 4000) begin prev = int'(a3); cyc(); n++; end
    chk("r3_latency_clk", n, 3000);
    chk("r3_before_last", prev, 54);

    // Setpoint latch table, including saturation; setpoint holds without strobe.
    for (int i = 0; i < 7; i++) begin
      strobe(int'(tbl[i].rpm));
      chk("latch", int'(z1), tbl[i].exp_zad);
      cyc();
      chk("latch_hold", int'(z1), tbl[i].exp_zad);
    end

    // Full duty after saturated setpoint.
    wait_a1("ramp_to_100", 100, 12000);
    hi = 0;
    repeat (200) begin cyc(); hi += int'(p1); end
    chk("duty100_high_cycles", hi, 200);

    // Ramp down, drop enable at 40: duty forced to 0 next cycle.
    strobe(0);
    wait_a1("down_to_40", 40, 13000);
    en = 1'b0;
    cyc();
    chk("disable_akt", int'(a1), 0);
    chk("disable_pwm", int'(p1), 0);
    chk("disable_wr", int'(w1), 0);
    strobe(50);
    chk("latch_while_off", int'(z1), 50);
    en = 1'b1;
    wait_a1("reenable_to_50", 50, 11000);

    // Reversal: ramping to 80, at 60 new setpoint 55.
    strobe(80);
    wait_a1("up_to_60", 60, 2500);
    strobe(55);
    mx = int'(a1);
    n = 0;
    while ((int'(a1) != 55 || w1) && n < 3000) begin
      if (int'(a1) > mx) mx = int'(a1);
      cyc();
      n++;
    end
    chk("rev_max", mx, 60);
    chk("rev_final", int'(a1), 55);

    // Strobe equal to current duty mid-ramp: ramp ends next cycle.
    strobe(70);
    wait_a1("up_to_57", 57, 1000);
    strobe(57);
    chk("equal_stops_wr", int'(w1), 0);

    // Ramp to zero: constant low.
    strobe(0);
    wait_a1("ramp_to_0", 0, 12000);
    hi = 0;
    repeat (200) begin cyc(); hi += int'(p1); end
    chk("duty0_high_cycles", hi, 0);

    // Randomized phase against the model.
    repeat (4000) begin
      if ($urandom_range(0, 39) == 0) begin
        rpm = 7'($urandom_range(0, 127));
        stb = 1'b1;
      end else begin
        stb = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) en = ~en;
      cyc();
    end
    stb = 1'b0;
    en  = 1'b1;

    // Asynchronous reset mid-ramp, between edges.
    strobe((int'(a1) > 50) ? 0 : 100);
    repeat (3) cyc();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_zad", int'(z1), 50);
    chk("async_akt", int'(a1), 0);
    chk("async_pwm", int'(p1), 0);
    chk("async_wr",  int'(w1), 0);
    chk("async_akt_r3", int'(a3), 0);
    m1 = mreset();
    m3 = mreset();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2000) cyc();
    chk("resoft_akt", int'(a1), 10);
    chk("resoft_wr", int'(w1), 1);
    chk("resoft_akt_r3", int'(a3), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
